// File: rtl/pu_div_seq_pkg.sv
// rtl/pu_div_seq_pkg.sv - shared types and sizing helpers for the iterative divider PU
package pu_div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } state_t;

   // Number of ITER cycles needed to resolve w quotient bits at bpc bits per cycle.
   function automatic int calc_steps(input int w, input int bpc);
      return (w + bpc - 1) / bpc;
   endfunction

   // Counter width able to hold steps-1 (at least one bit).
   function automatic int calc_cnt_w(input int steps);
      return (steps <= 2) ? 1 : $clog2(steps);
   endfunction

   // Largest positive two's complement value of a dw-bit word.
   function automatic logic [63:0] sat_pos(input int dw);
      return (64'd1 << (dw - 1)) - 64'd1;
   endfunction

   // Most negative two's complement value of a dw-bit word (low dw bits).
   function automatic logic [63:0] sat_neg(input int dw);
      return 64'd1 << (dw - 1);
   endfunction

endpackage

// File: rtl/pu_div_seq_div_step.sv
// rtl/pu_div_seq_div_step.sv - combinational multi-bit restoring division stage
module div_step
   import pu_div_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [DATA_WIDTH:0]       rem_in,
   input  logic [DATA_WIDTH-1:0]     divisor,
   input  logic [BITS_PER_CYCLE-1:0] num_bits,
   output logic [DATA_WIDTH:0]       rem_out,
   output logic [BITS_PER_CYCLE-1:0] q_bits
);

   logic [DATA_WIDTH:0] r;
   logic [DATA_WIDTH:0] t;

   // Shift in one numerator bit at a time (MSB first) and subtract when it fits.
   always_comb begin
      r      = rem_in;
      t      = '0;
      q_bits = '0;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
         t = {r[DATA_WIDTH-1:0], num_bits[i]};
         if (t >= {1'b0, divisor}) begin
            r         = t - {1'b0, divisor};
            q_bits[i] = 1'b1;
         end else begin
            r = t;
         end
      end
      rem_out = r;
   end

endmodule

// File: rtl/pu_div_seq.sv
// rtl/pu_div_seq.sv - iterative signed fixed-point divider PU; PU_DIV_SAT_EN enables quotient saturation
module pu_div_seq
   import pu_div_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ATTR_WIDTH     = 4,
   parameter int INVALID        = 0,
   parameter int FRAC_BITS      = 0,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signal_sel,
   input  logic                  signal_wr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   input  logic                  signal_oe,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out,
   output logic                  busy
);

   localparam int W     = DATA_WIDTH + FRAC_BITS;
   localparam int STEPS = calc_steps(W, BITS_PER_CYCLE);
   localparam int NW    = STEPS * BITS_PER_CYCLE;
   localparam int CW    = calc_cnt_w(STEPS);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);
`ifdef PU_DIV_SAT_EN
   localparam logic [DATA_WIDTH-1:0] SAT_POS = DATA_WIDTH'(sat_pos(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SAT_NEG = DATA_WIDTH'(sat_neg(DATA_WIDTH));
`endif

   state_t state, state_nxt;

   logic start, load, rd;
   logic [DATA_WIDTH-1:0] numer_r, denom_r, op_n, op_d;
   logic numer_inv, denom_inv, op_inv;
   logic n_neg, q_neg, d_zero;
   logic [DATA_WIDTH-1:0] d_mag, n_mag_w, d_mag_w;
   logic [DATA_WIDTH:0] rem, rem_nxt;
   logic [NW-1:0] dq;
   logic [BITS_PER_CYCLE-1:0] q_bits;
   logic [CW-1:0] cnt;
   logic [DATA_WIDTH-1:0] q_res, r_res;
   logic inv_res;
   logic [NW:0] qx;
   logic ovf;
   logic [DATA_WIDTH-1:0] q_fix, r_fix;
   logic inv_fix;
   logic unused_attr;

   assign start   = signal_oe & signal_wr;
   assign load    = signal_wr & ~signal_oe;
   assign rd      = signal_oe & ~signal_wr;
   assign n_mag_w = op_n[DATA_WIDTH-1] ? -op_n : op_n;
   assign d_mag_w = op_d[DATA_WIDTH-1] ? -op_d : op_d;
   assign unused_attr = ^attr_in;

   div_step #(
      .DATA_WIDTH     (DATA_WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .rem_in   (rem),
      .divisor  (d_mag),
      .num_bits (dq[NW-1 -: BITS_PER_CYCLE]),
      .rem_out  (rem_nxt),
      .q_bits   (q_bits)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a start always (re)enters PREP.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = PREP;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            PREP:    state_nxt = (op_d == '0) ? FIX : ITER;
            ITER:    state_nxt = (cnt == '0) ? FIX : ITER;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      busy = (state != IDLE);
   end

   // Operand registers; independent of any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         numer_r   <= '0;
         denom_r   <= '0;
         numer_inv <= 1'b0;
         denom_inv <= 1'b0;
      end else if (load) begin
         if (signal_sel) begin
            numer_r   <= data_in;
            numer_inv <= attr_in[INVALID];
         end else begin
            denom_r   <= data_in;
            denom_inv <= attr_in[INVALID];
         end
      end
   end

   // Overflow when the exact magnitude does not fit the signed result range.
   always_comb begin
      qx  = {1'b0, dq};
      ovf = (|qx[NW:DATA_WIDTH]) |
            (qx[DATA_WIDTH-1] & (~q_neg | (|qx[DATA_WIDTH-2:0])));
   end

   // Sign correction and exception handling of the final result.
   always_comb begin
      q_fix   = q_neg ? -qx[DATA_WIDTH-1:0] : qx[DATA_WIDTH-1:0];
      r_fix   = n_neg ? -rem[DATA_WIDTH-1:0] : rem[DATA_WIDTH-1:0];
      inv_fix = op_inv | d_zero | ovf;
      if (d_zero) begin
         r_fix = op_n;
`ifdef PU_DIV_SAT_EN
         q_fix = q_neg ? SAT_NEG : SAT_POS;
`else
         q_fix = '0;
`endif
      end else if (ovf) begin
`ifdef PU_DIV_SAT_EN
         q_fix = q_neg ? SAT_NEG : SAT_POS;
`endif
      end
   end

   // Datapath: latch at start, prepare magnitudes, iterate, commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_n    <= '0;
         op_d    <= '0;
         op_inv  <= 1'b0;
         n_neg   <= 1'b0;
         q_neg   <= 1'b0;
         d_zero  <= 1'b0;
         d_mag   <= '0;
         rem     <= '0;
         dq      <= '0;
         cnt     <= '0;
         q_res   <= '0;
         r_res   <= '0;
         inv_res <= 1'b0;
      end else begin
         if (start) begin
            op_n   <= numer_r;
            op_d   <= denom_r;
            op_inv <= numer_inv | denom_inv;
         end
         case (state)
            PREP: begin
               n_neg  <= op_n[DATA_WIDTH-1];
               q_neg  <= op_n[DATA_WIDTH-1] ^ op_d[DATA_WIDTH-1];
               d_zero <= (op_d == '0);
               d_mag  <= d_mag_w;
               dq     <= NW'(n_mag_w) << FRAC_BITS;
               rem    <= '0;
               cnt    <= CNT_LAST;
            end
            ITER: begin
               rem <= rem_nxt;
               dq  <= (dq << BITS_PER_CYCLE) | NW'(q_bits);
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               if (!start) begin
                  q_res   <= q_fix;
                  r_res   <= r_fix;
                  inv_res <= inv_fix;
               end
            end
            default: ;
         endcase
      end
   end

   // Combinational read port from the committed result.
   always_comb begin
      data_out = '0;
      attr_out = '0;
      if (rd) begin
         data_out          = signal_sel ? r_res : q_res;
         attr_out[INVALID] = inv_res;
      end
   end

endmodule

// File: tb/tb_pu_div_seq.sv
// tb/tb_pu_div_seq.sv - directed self-checking bench for pu_div_seq
module tb_pu_div_seq;

   logic        clk;
   logic        rst;
   logic        sel, wr, oe;
   logic [31:0] din;
   logic [3:0]  ain;
   logic [31:0] dout, dout_f;
   logic [3:0]  aout, aout_f;
   logic        busy, busy_f;

   int vectors = 0;
   int miscompares = 0;

   pu_div_seq dut (
      .clk (clk), .rst (rst), .signal_sel (sel), .signal_wr (wr),
      .data_in (din), .attr_in (ain), .signal_oe (oe),
      .data_out (dout), .attr_out (aout), .busy (busy)
   );

   pu_div_seq #(
      .DATA_WIDTH (32), .ATTR_WIDTH (4), .INVALID (0),
      .FRAC_BITS (8), .BITS_PER_CYCLE (4)
   ) dut_f (
      .clk (clk), .rst (rst), .signal_sel (sel), .signal_wr (wr),
      .data_in (din), .attr_in (ain), .signal_oe (oe),
      .data_out (dout_f), .attr_out (aout_f), .busy (busy_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic s, input logic [31:0] d, input logic inv);
      sel = s; wr = 1'b1; oe = 1'b0; din = d; ain = {3'b000, inv};
      tick();
      wr = 1'b0; ain = '0; din = '0; sel = 1'b0;
   endtask

   task automatic start_op();
      wr = 1'b1; oe = 1'b1;
      tick();
      wr = 1'b0; oe = 1'b0;
   endtask

   task automatic rd(input logic s, output logic [31:0] d, output logic inv,
                     output logic [31:0] df, output logic invf);
      sel = s; oe = 1'b1; wr = 1'b0;
      #1;
      d = dout; inv = aout[0]; df = dout_f; invf = aout_f[0];
      #1;
      oe = 1'b0; sel = 1'b0;
   endtask

   task automatic wait_done(input bit use_f, output int edges);
      edges = 0;
      while ((use_f ? busy_f : busy) && edges < 200) begin
         tick();
         edges++;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || busy_f) && n < 200) begin
         tick();
         n++;
      end
      chk("idle", {63'd0, busy | busy_f}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q, r, qf, rf;
      logic iv, ivf, iv2, ivf2;
      int lat, bad;

      rst = 1'b1; sel = 1'b0; wr = 1'b0; oe = 1'b0; din = '0; ain = '0;
      tick(); tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rd(1'b0, q, iv, qf, ivf);
      chk("rst_q", q, 0);
      chk("rst_inv", {63'd0, iv}, 64'd0);
      rd(1'b1, r, iv, rf, ivf);
      chk("rst_r", r, 0);
      rst = 1'b0;
      tick();

      // 100 / 7
      load(1'b1, 32'd100, 1'b0);
      load(1'b0, 32'd7, 1'b0);
      start_op();
      chk("t1_busy", {63'd0, busy}, 64'd1);
      wait_done(1'b0, lat);
      chk("t1_lat", lat, 34);
      rd(1'b0, q, iv, qf, ivf);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t1_q", q, 14);
      chk("t1_r", r, 2);
      chk("t1_inv", {63'd0, iv}, 64'd0);
      wait_idle();

      // -100 / 7 and 100 / -7
      load(1'b1, 32'hFFFF_FF9C, 1'b0);
      start_op();
      wait_done(1'b0, lat);
      rd(1'b0, q, iv, qf, ivf);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t2a_q", q, 32'hFFFF_FFF2);
      chk("t2a_r", r, 32'hFFFF_FFFE);
      wait_idle();
      load(1'b1, 32'd100, 1'b0);
      load(1'b0, 32'hFFFF_FFF9, 1'b0);
      start_op();
      wait_done(1'b0, lat);
      rd(1'b0, q, iv, qf, ivf);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t2b_q", q, 32'hFFFF_FFF2);
      chk("t2b_r", r, 2);
      wait_idle();

      // 5 / 0
      load(1'b1, 32'd5, 1'b0);
      load(1'b0, 32'd0, 1'b0);
      start_op();
      wait_done(1'b0, lat);
      chk("t3_lat", lat, 2);
      rd(1'b0, q, iv, qf, ivf);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t3_inv", {63'd0, iv}, 64'd1);
      chk("t3_r", r, 5);
`ifdef PU_DIV_SAT_EN
      chk("t3_q", q, 32'h7FFF_FFFF);
`else
      chk("t3_q", q, 0);
`endif
      wait_idle();

      // 0x80000000 / -1
      load(1'b1, 32'h8000_0000, 1'b0);
      load(1'b0, 32'hFFFF_FFFF, 1'b0);
      start_op();
      wait_done(1'b0, lat);
      rd(1'b0, q, iv, qf, ivf);
      chk("t4_inv", {63'd0, iv}, 64'd1);
`ifdef PU_DIV_SAT_EN
      chk("t4_q", q, 32'h7FFF_FFFF);
`else
      chk("t4_q", q, 32'h8000_0000);
`endif
      wait_idle();

      // FRAC=8, BPC=4: 0x100 / 0x200
      load(1'b1, 32'h100, 1'b0);
      load(1'b0, 32'h200, 1'b0);
      start_op();
      wait_done(1'b1, lat);
      chk("t5_lat", lat, 12);
      rd(1'b0, q, iv, qf, ivf);
      chk("t5_q", qf, 32'h80);
      chk("t5_inv", {63'd0, ivf}, 64'd0);
      wait_idle();
      load(1'b1, 32'h100, 1'b1);
      start_op();
      wait_done(1'b1, lat);
      rd(1'b0, q, iv, qf, ivf);
      chk("t5b_q", qf, 32'h80);
      chk("t5b_inv", {63'd0, ivf}, 64'd1);
      wait_idle();
      // default instance now holds 0x100/0x200 unscaled: q=0, r=0x100, invalid

      // restart mid-ITER; busy reads return the old result
      load(1'b1, 32'd100, 1'b0);
      load(1'b0, 32'd7, 1'b0);
      start_op();
      for (int i = 0; i < 4; i++) tick();
      rd(1'b0, q, iv, qf, ivf);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t6_busy_q", q, 0);
      chk("t6_busy_r", r, 32'h100);
      chk("t6_busy_inv", {63'd0, iv}, 64'd1);
      load(1'b1, 32'd9, 1'b0);
      load(1'b0, 32'd3, 1'b0);
      start_op();
      bad = 0;
      lat = 0;
      while (busy && lat < 200) begin
         rd(1'b0, q, iv, qf, ivf);
         if (q !== 32'd0 || iv !== 1'b1) bad++;
         tick();
         lat++;
      end
      chk("t6_busy_reads", bad, 0);
      chk("t6_lat", lat, 34);
      rd(1'b0, q, iv, qf, ivf);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t6_q", q, 3);
      chk("t6_r", r, 0);
      chk("t6_inv", {63'd0, iv}, 64'd0);
      wait_idle();

      // reset mid-ITER
      start_op();
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t7_busy", {63'd0, busy}, 64'd0);
      chk("t7_busy_f", {63'd0, busy_f}, 64'd0);
      rd(1'b0, q, iv, qf, ivf);
      chk("t7_q", q, 0);
      chk("t7_attr", {60'd0, aout}, 64'd0);
      rd(1'b1, r, iv2, rf, ivf2);
      chk("t7_r", r, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
